// File: rtl/fetch_pkg.sv
// Shared constants and buffer entry type for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;
  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small in-order fetch buffer. The head is always entry 0, so the output is registered
// and stays stable until it is popped.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [FETCH_CNT_W-1:0] count_o
);

  fetch_entry_t           ent_q [FETCH_BUF_DEPTH];
  fetch_entry_t           ent_d [FETCH_BUF_DEPTH];
  logic [FETCH_CNT_W-1:0] count_q, count_d;
  logic [FETCH_CNT_W-1:0] slot;
  logic                   pop_eff;

  always_comb begin
    pop_eff = pop_i && (count_q != '0);
    // A push lands behind whatever remains after this cycle's pop.
    slot    = count_q - FETCH_CNT_W'(pop_eff);
    ent_d   = ent_q;
    if (pop_eff) begin
      for (int i = 0; i < int'(FETCH_BUF_DEPTH) - 1; i++) begin
        ent_d[i] = ent_q[i+1];
      end
    end
    if (push_i) begin
      for (int i = 0; i < int'(FETCH_BUF_DEPTH); i++) begin
        if (slot == FETCH_CNT_W'(i)) begin
          ent_d[i] = push_data_i;
        end
      end
    end
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + FETCH_CNT_W'(push_i) - FETCH_CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ent_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign head_o  = ent_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, one-cycle ROM requests, redirect handling,
// and a two-entry buffer towards decode.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0]            pc_q, pc_d;
  logic [31:0]            req_pc_q, req_pc_d;
  logic                   req_q, req_d;
  logic [FETCH_CNT_W-1:0] count;
  logic [FETCH_CNT_W:0]   committed;
  logic                   pop;
  logic                   push;
  logic                   issue;
  fetch_entry_t           push_entry;
  fetch_entry_t           head;

  assign pop = out_valid && out_ready;

  always_comb begin
    // Slots already claimed after this cycle: buffered + in flight - leaving now.
    committed  = {1'b0, count} + (FETCH_CNT_W+1)'(req_q) - (FETCH_CNT_W+1)'(pop);
    issue      = !redirect_valid && (committed < (FETCH_CNT_W+1)'(FETCH_BUF_DEPTH));
    push       = req_q && !redirect_valid;
    push_entry = '{pc: req_pc_q, instr: rom_data};
    req_d      = issue;
    req_pc_d   = req_pc_q;
    pc_d       = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      pc_d     = pc_q + PC_STEP;
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buf u_buf (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign rom_addr  = pc_q;
  assign out_valid = (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect/reset
// traffic checked against a transaction-level model of the delivered instruction stream.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // ROM word n holds 0x1000_0000 + n.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge CLK) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the delivered stream is contiguous from the last reset/redirect target, each
  // instruction equals the ROM word at its PC, at most two fetched-but-undelivered words
  // exist, valid never drops except in the two cycles after a restart, and a stalled
  // head holds still.
  logic [31:0] exp_pc = '0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;
  logic [31:0] ahead;
  logic        hold = 1'b0;
  int          inv_run = 0;

  always @(negedge CLK) begin
    #1;
    if (!RST) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_addr", rom_addr, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_instr", out_instr, 32'd0);
      exp_pc  = '0;
      inv_run = 0;
      hold    = 1'b0;
    end else begin
      ahead = rom_addr - exp_pc;
      check("fetch_window", 32'(ahead == 0 || ahead == 4 || ahead == 8), 32'd1);
      if (hold) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_pc", out_pc, hold_pc);
        check("stall_instr", out_instr, hold_instr);
      end
      if (!out_valid) begin
        inv_run++;
        check("valid_gap", 32'(inv_run <= 2), 32'd1);
      end
      if (out_valid && out_ready) begin
        check("deliver_pc", out_pc, exp_pc);
        check("deliver_instr", out_instr, rom_fn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      hold       = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      if (redirect_valid) begin
        exp_pc  = {redirect_pc[31:2], 2'b00};
        inv_run = 0;
      end
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) cyc();
    // Reset release, streaming with out_ready = 1.
    cyc(); RST = 1'b1;
    #2 check("d_rel_addr", rom_addr, 32'h0);
    cyc(); #2;
    check("d_lat_valid0", 32'(out_valid), 32'd0);
    check("d_lat_addr", rom_addr, 32'h4);
    cyc(); #2;
    check("d_first_valid", 32'(out_valid), 32'd1);
    check("d_first_pc", out_pc, 32'h0);
    check("d_first_instr", out_instr, 32'h1000_0000);
    cyc(); #2;
    check("d_second_pc", out_pc, 32'h4);
    check("d_second_instr", out_instr, 32'h1000_0001);
    cyc(); #2 check("d_third_pc", out_pc, 32'h8);
    // Stall for five cycles: buffer fills with 12 and 16, fetch stops at 20.
    cyc(); out_ready = 1'b0;
    repeat (4) cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    #2;
    check("d_full_pc", out_pc, 32'hC);
    check("d_full_instr", out_instr, 32'h1000_0003);
    check("d_full_addr", rom_addr, 32'h14);
    cyc(); redirect_valid = 1'b0;
    #2;
    check("d_redir_addr", rom_addr, 32'h40);
    check("d_redir_flush", 32'(out_valid), 32'd0);
    cyc(); #2 check("d_redir_wait", 32'(out_valid), 32'd0);
    cyc(); #2;
    check("d_redir_valid", 32'(out_valid), 32'd1);
    check("d_redir_pc", out_pc, 32'h40);
    check("d_redir_instr", out_instr, 32'h1000_0010);
    // Redirect with a simultaneous pop of head 0x40.
    cyc(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc(); redirect_valid = 1'b0;
    #2 check("d_pop_redir_empty", 32'(out_valid), 32'd0);
    cyc();
    cyc(); #2 check("d_pop_redir_pc", out_pc, 32'h200);
    // Wrap-around target.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect_valid = 1'b0;
    cyc();
    cyc(); #2;
    check("d_wrap_pc0", out_pc, 32'hFFFF_FFFC);
    check("d_wrap_instr0", out_instr, 32'h4FFF_FFFF);
    cyc(); #2;
    check("d_wrap_pc1", out_pc, 32'h0);
    check("d_wrap_instr1", out_instr, 32'h1000_0000);
    cyc(); #2 check("d_wrap_pc2", out_pc, 32'h4);
    // Reset pulse with one buffered entry and a request in flight.
    cyc(); RST = 1'b0;
    #2;
    check("d_arst_valid", 32'(out_valid), 32'd0);
    check("d_arst_addr", rom_addr, 32'h0);
    cyc(); RST = 1'b1;
    cyc(); #2 check("d_arst_wait", 32'(out_valid), 32'd0);
    cyc(); #2;
    check("d_arst_pc", out_pc, 32'h0);
    check("d_arst_instr", out_instr, 32'h1000_0000);
    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      RST            = ($urandom_range(0, 299) != 0);
      out_ready      = ((c / 250) % 2 == 0) ? ($urandom_range(0, 7) != 0)
                                            : ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
    end
    cyc(); RST = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    check("progress", 32'(xfers > 1500), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rom_addr, output, 32 bits: byte address to the instruction ROM; the ROM samples it at a CLK edge and returns data on rom_data in the following cycle.
REQ-004 SHALL have port rom_data, input, 32 bits: ROM read data for the address sampled at the previous edge.
REQ-005 SHALL have port redirect_valid, input, 1 bit: branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc, input, 32 bits: target byte address; bits [1:0] are ignored and treated as 00.
REQ-007 SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a fetched instruction.
REQ-008 SHALL have port out_ready, input, 1 bit: decode stage accepts the instruction; a transfer occurs when out_valid and out_ready are both 1.
REQ-009 SHALL have port out_instr, output, 32 bits: instruction word.
REQ-010 SHALL have port out_pc, output, 32 bits: byte address of out_instr.

Function
REQ-011 SHALL hold pc_q (next fetch address) and drive rom_addr = pc_q combinationally.
REQ-012 SHALL issue a request in a cycle iff count + req_q - pop < 2 and redirect_valid = 0, where count = buffer occupancy (0..2), req_q = request in flight, and pop = transfer this cycle.
REQ-013 On issue, SHALL set pc_q <= pc_q + 4 (modulo 2^32; 0xFFFFFFFC wraps to 0), req_q <= 1, and req_pc_q <= pc_q; otherwise SHALL set req_q <= 0 and hold pc_q.
REQ-014 When req_q = 1 and the response is not killed, SHALL write {req_pc_q, rom_data} into the 2-entry in-order buffer at that cycle's edge.
REQ-015 SHALL drive out_valid = (count != 0), with out_instr/out_pc taken from the buffer head (registered, no bypass); issue-to-out_valid latency is 2 cycles.
REQ-016 Simultaneous push and pop SHALL leave count unchanged and preserve order; pop while empty SHALL have no effect; the REQ-012 rule guarantees no push when full.
REQ-017 With out_ready held at 1, SHALL sustain one instruction per cycle after the initial 2-cycle latency.
REQ-018 On redirect_valid = 1 at cycle t: SHALL clear the buffer, discard any response arriving at t, set req_q <= 0, set pc_q <= {redirect_pc[31:2], 2'b00}, and not issue at t; the first target request issues at t+1 and its out_valid rises at t+3.
REQ-019 A pop coinciding with redirect_valid SHALL be honoured for the current head; the flush still takes effect.
REQ-020 out_instr/out_pc SHALL hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-021 While RST = 0: pc_q = 0x00000000, req_q = 0, req_pc_q = 0, count = 0, out_valid = 0, out_instr = 0, out_pc = 0, rom_addr = 0.
REQ-022 Assertion mid-operation SHALL abort any in-flight request and empty the buffer immediately; the first request after release is to address 0 at the first edge with RST = 1.

Structure
REQ-023 Shared package fetch_pkg SHALL hold RESET_PC = 32'h0, PC_STEP = 4, FETCH_BUF_DEPTH = 2, and the {pc, instr} entry typedef.
REQ-024 The 2-entry buffer SHALL be a sub-module fetch_buf with push/pop/flush and count outputs; issue, PC, and redirect logic stays in fetch_unit.

Verification
REQ-025 Reset release, out_ready = 1, ROM word n = 0x1000_0000 + n -> rom_addr 0,4,8,...; out_valid rises 2 cycles after the first edge; (out_pc, out_instr) = (0, 0x10000000), (4, 0x10000001), ... one per cycle.
REQ-026 out_ready = 0 for 5 cycles in steady state -> count reaches 2; issue stops; no entry lost or duplicated; after out_ready returns to 1, the sequence continues contiguously.
REQ-027 redirect_valid = 1 with redirect_pc = 0x00000043 while the buffer is full -> buffer flushed; next rom_addr = 0x40; out_pc = 0x40 appears exactly 3 cycles after the redirect cycle; no stale PC is delivered.
REQ-028 Redirect and pop in the same cycle -> the head is consumed once; the next delivered out_pc is the target.
REQ-029 redirect_pc = 0xFFFFFFFC -> delivered out_pc sequence is 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-030 RST pulsed low for 1 cycle while a request is in flight and count = 1 -> out_valid = 0 asynchronously; after release, fetch restarts at 0 and the pre-reset response never appears.
